// File: rtl/mem_access_ctrl_if.sv
// Request and data-RAM bus of the M-stage memory access controller.
// The slave modport is the controller; the master modport is the pipeline/RAM side.
interface mem_access_ctrl_if;
  // Pipeline request
  logic        req_valid;
  logic        req_write;
  logic [1:0]  sw_mode;
  logic [31:0] addr;
  logic [31:0] wdata;

  // Pipeline response
  logic [31:0] rdata_out;
  logic        done;
  logic        stall;

  // Single-port data RAM
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_valid, req_write, sw_mode, addr, wdata, ram_rdata,
    output rdata_out, done, stall, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_write, sw_mode, addr, wdata, ram_rdata,
    input  rdata_out, done, stall, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller for a single-port data RAM.
// sw completes in the accepting cycle, lw waits one cycle for RAM data, and
// swl/swr do a read-modify-write over three cycles (read, merge, write).
module mem_access_ctrl (
  input logic              clk,
  input logic              reset,  // asynchronous, active-low
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StLdWait,
    StRmwRd,
    StRmwWr
  } state_e;

  localparam logic [1:0] ModeSwl = 2'b01;
  localparam logic [1:0] ModeSwr = 2'b10;

  state_e      state_q, state_d;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  mode_q;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        latch_en;

  logic        is_partial;
  logic        ram_en, ram_we, done, stall;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, rdata_out;

  // Only the low 12 address bits reach the 1K-word RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:12];

  // Little-endian swl/swr byte merge of store data into the old word.
  function automatic logic [31:0] merge_word(input logic        is_swl,
                                             input logic [1:0]  b,
                                             input logic [31:0] m,
                                             input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (is_swl) begin
      case (b)
        2'd0:    r = {m[31:8], w[31:24]};
        2'd1:    r = {m[31:16], w[31:16]};
        2'd2:    r = {m[31:24], w[31:8]};
        default: r = w;
      endcase
    end else begin
      case (b)
        2'd0:    r = w;
        2'd1:    r = {w[23:0], m[7:0]};
        2'd2:    r = {w[15:0], m[15:0]};
        default: r = {w[7:0], m[23:0]};
      endcase
    end
    return r;
  endfunction

  // sw_mode 11 falls through to a plain full-word store.
  assign is_partial = bus.req_write && ((bus.sw_mode == ModeSwl) || (bus.sw_mode == ModeSwr));

  // Next-state and output decode; outputs in IDLE depend on the incoming request.
  always_comb begin
    state_d   = state_q;
    merged_d  = merged_q;
    rdata_d   = rdata_q;
    latch_en  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q[11:2];
    ram_wdata = wdata_q;
    done      = 1'b0;
    stall     = 1'b0;
    rdata_out = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          latch_en = 1'b1;
          ram_en   = 1'b1;
          ram_addr = bus.addr[11:2];
          if (!bus.req_write) begin
            stall   = 1'b1;
            state_d = StLdWait;
          end else if (is_partial) begin
            stall   = 1'b1;
            state_d = StRmwRd;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = bus.wdata;
            done      = 1'b1;
          end
        end
      end
      StLdWait: begin
        rdata_out = bus.ram_rdata;
        rdata_d   = bus.ram_rdata;
        done      = 1'b1;
        state_d   = StIdle;
      end
      StRmwRd: begin
        // RAM data for the read issued in IDLE is valid now.
        merged_d = merge_word(mode_q == ModeSwl, addr_q[1:0], bus.ram_rdata, wdata_q);
        stall    = 1'b1;
        state_d  = StRmwWr;
      end
      StRmwWr: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = merged_q;
        done      = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset is asynchronous, so outputs must be quiet even before the next edge;
    // this also kills a pending RMW write.
    if (!reset) begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      done      = 1'b0;
      stall     = 1'b0;
      rdata_out = '0;
    end
  end

  // State, latched request and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      if (latch_en) begin
        addr_q  <= bus.addr[11:0];
        wdata_q <= bus.wdata;
        mode_q  <= bus.sw_mode;
      end
    end
  end

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.done      = done;
  assign bus.stall     = stall;
  assign bus.rdata_out = rdata_out;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues accesses and queues the
// expected response from a byte-level memory model; a monitor checks each done pulse.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic reset;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data appears one cycle after the strobe.
  logic [31:0] ram_mem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    logic [9:0]  waddr;
    int          stalls;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [1024];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one access, queue its expectation, and hold it until done is seen.
  task automatic issue(input bit wr, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t        e;
    int          b;
    logic [31:0] nw;
    bit          got;
    b        = int'(a[1:0]);
    e.waddr  = a[11:2];
    e.is_load = !wr;
    if (!wr) begin
      e.data   = ref_mem[a[11:2]];
      e.stalls = 1;
    end else if (mode == 2'b01 || mode == 2'b10) begin
      nw = ref_mem[a[11:2]];
      for (int i = 0; i < 4; i++) begin
        if (mode == 2'b01 && i <= b) nw[8*i +: 8] = d[8*(3-b+i) +: 8];
        if (mode == 2'b10 && i >= b) nw[8*i +: 8] = d[8*(i-b) +: 8];
      end
      e.data   = nw;
      e.stalls = 2;
    end else begin
      e.data   = d;
      e.stalls = 0;
    end
    if (wr) ref_mem[a[11:2]] = e.data;
    exp_q.push_back(e);

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.sw_mode   = mode;
    bus.addr      = a;
    bus.wdata     = d;
    got = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no done for access at addr %h", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per done pulse and counts stall cycles per access.
  int          stall_cnt = 0;
  logic [31:0] last_load = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_cnt = 0;
        last_load = '0;
      end else begin
        if (bus.ram_we) chk("write_without_done", bus.done, 1'b1);
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: done=1 with empty scoreboard (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("stall_cycles", stall_cnt, e.stalls);
            chk("stall_at_done", bus.stall, 1'b0);
            if (e.is_load) begin
              chk("load_data", bus.rdata_out, e.data);
              chk("load_no_write", bus.ram_we, 1'b0);
              last_load = e.data;
            end else begin
              chk("store_en", bus.ram_en, 1'b1);
              chk("store_we", bus.ram_we, 1'b1);
              chk("store_addr", bus.ram_addr, e.waddr);
              chk("store_data", bus.ram_wdata, e.data);
              chk("rdata_hold", bus.rdata_out, last_load);
            end
          end
          stall_cnt = 0;
        end else if (bus.stall) begin
          stall_cnt++;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // Reset with a live store request: outputs must stay quiet.
    reset         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.sw_mode   = 2'b00;
    bus.addr      = 32'h10;
    bus.wdata     = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ram_en", bus.ram_en, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_rdata", bus.rdata_out, 32'h0);
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    issue(1, 2'b00, 32'h010, 32'hDEAD_BEEF);
    issue(0, 2'b00, 32'h010, 32'h0);
    issue(1, 2'b00, 32'h004, 32'h1122_3344);
    issue(1, 2'b01, 32'h005, 32'hAABB_CCDD);
    issue(0, 2'b00, 32'h004, 32'h0);
    issue(1, 2'b00, 32'h004, 32'h1122_3344);
    issue(1, 2'b10, 32'h006, 32'hAABB_CCDD);
    issue(1, 2'b00, 32'h004, 32'h1122_3344);
    issue(1, 2'b10, 32'h007, 32'hAABB_CCDD);
    idle(2);

    // Back-to-back lw then swl with req_valid held high.
    issue(0, 2'b00, 32'h013, 32'h0);
    issue(1, 2'b01, 32'h011, 32'h0102_0304);
    idle(1);

    // Reset while in RMW_RD: the swl must never write.
    issue(1, 2'b00, 32'h004, 32'h1122_3344);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.sw_mode   = 2'b01;
    bus.addr      = 32'h005;
    bus.wdata     = 32'h5566_7788;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_stall", bus.stall, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_ram_en", bus.ram_en, 1'b0);
    chk("abort_rdata", bus.rdata_out, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk("abort_ram_we", bus.ram_we, 1'b0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 2'b00, 32'h020, 32'hCAFE_F00D);
    issue(0, 2'b00, 32'h004, 32'h0);
    issue(0, 2'b00, 32'h020, 32'h0);

    // Randomized mix over a small address window so RMW hits prior stores.
    for (int k = 0; k < 200; k++) begin
      bit          wr;
      logic [1:0]  mode;
      logic [31:0] a;
      wr   = ($urandom_range(0, 2) != 0);
      mode = 2'($urandom_range(0, 3));
      a    = {$urandom_range(0, 15)} << 2 | 32'($urandom_range(0, 3));
      a    = a | ({$urandom_range(0, 7)} << 12);
      issue(wr, mode, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
